// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator scheduler and the car controller:
// floor codes, scheduler states, display patterns and car status codes.
package elevator_pkg;

    localparam int N_FLOORS = 8;
    localparam int FLOOR_W  = 4;

    // Floor codes; code 0 is never a legal position.
    localparam logic [FLOOR_W-1:0] FLOOR_NONE = 4'd0;
    localparam logic [FLOOR_W-1:0] FLOOR_G    = 4'd1;
    localparam logic [FLOOR_W-1:0] FLOOR_1    = 4'd2;
    localparam logic [FLOOR_W-1:0] FLOOR_2    = 4'd3;
    localparam logic [FLOOR_W-1:0] FLOOR_3    = 4'd4;
    localparam logic [FLOOR_W-1:0] FLOOR_4    = 4'd5;
    localparam logic [FLOOR_W-1:0] FLOOR_5    = 4'd6;
    localparam logic [FLOOR_W-1:0] FLOOR_6    = 4'd7;
    localparam logic [FLOOR_W-1:0] FLOOR_7    = 4'd8;

    // Scheduler sweep state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } sched_state_t;

    // Car travel direction as reported by the car controller.
    typedef enum logic [1:0] {
        DIR_STOP = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } car_dir_t;

    // Door status as reported by the car controller.
    typedef enum logic [1:0] {
        DOOR_CLOSED  = 2'd0,
        DOOR_OPENING = 2'd1,
        DOOR_OPEN    = 2'd2,
        DOOR_CLOSING = 2'd3
    } door_state_t;

    // Seven-segment patterns, bit order gfedcba, active-high.
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_G     = 7'h3D;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;

    // True when a floor code names a real floor.
    function automatic logic floor_code_legal(input logic [FLOOR_W-1:0] code);
        return (code != FLOOR_NONE) && (code <= FLOOR_W'(N_FLOORS));
    endfunction

    // Display pattern for a floor code; blank for illegal codes.
    function automatic logic [6:0] floor_to_seg(input logic [FLOOR_W-1:0] code);
        logic [6:0] seg;
        case (code)
            FLOOR_G: seg = SEG_G;
            FLOOR_1: seg = SEG_1;
            FLOOR_2: seg = SEG_2;
            FLOOR_3: seg = SEG_3;
            FLOOR_4: seg = SEG_4;
            FLOOR_5: seg = SEG_5;
            FLOOR_6: seg = SEG_6;
            FLOOR_7: seg = SEG_7;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One floor button: 2-flop synchroniser, level debouncer and a
// single-cycle pulse when the debounced level rises.
module btn_debounce
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic reset,
    input  logic btn_raw_i,
    output logic rise_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rise_q;
    logic             rise_d;

    // Count consecutive samples that disagree with the stable level; flip on the last one.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        rise_d   = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                rise_d   = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, debounce state and rise pulse registers.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
        end else begin
            sync1_q  <= btn_raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/elevator_request_scheduler.sv
// SCAN request scheduler: debounces floor buttons into pending requests,
// issues one target floor at a time and retires requests on arrival.
module elevator_request_scheduler
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic [N_FLOORS:1]   floor_btn,
    input  logic [FLOOR_W-1:0]  current_floor,
    input  logic                arrived,
    output logic [FLOOR_W-1:0]  target_floor,
    output logic                target_valid,
    output logic                target_strobe,
    output logic                dir_up,
    output logic                dir_down,
    output logic [N_FLOORS:1]   pending
);

    logic [N_FLOORS:1]  btn_rise;
    logic [N_FLOORS:1]  pending_q;
    logic [N_FLOORS:1]  pending_d;
    logic               floor_ok;

    sched_state_t       state_q;
    sched_state_t       state_d;
    logic [FLOOR_W-1:0] target_q;
    logic [FLOOR_W-1:0] target_d;
    logic               valid_q;
    logic               valid_d;
    logic               strobe_q;
    logic               strobe_d;
    logic               dir_up_q;
    logic               dir_down_q;

    logic               above_found;
    logic [FLOOR_W-1:0] above_floor;
    logic               below_found;
    logic [FLOOR_W-1:0] below_floor;
    logic               here_pending;
    logic [FLOOR_W-1:0] dist_up;
    logic [FLOOR_W-1:0] dist_down;
    logic               pick_up;

    genvar gi;
    generate
        for (gi = 1; gi <= N_FLOORS; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .CLK      (CLK),
                .reset    (reset),
                .btn_raw_i(floor_btn[gi]),
                .rise_o   (btn_rise[gi])
            );
        end
    endgenerate

    assign floor_ok = floor_code_legal(current_floor);

    // New requests set bits; an arrival at a legal floor clears its bit and wins a collision.
    always_comb begin
        pending_d = pending_q | btn_rise;
        for (int k = 1; k <= N_FLOORS; k++) begin
            if (arrived && floor_ok && (current_floor == FLOOR_W'(k))) begin
                pending_d[k] = 1'b0;
            end
        end
    end

    // Pending request register.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Nearest pending floor above (lowest) and below (highest) the car.
    always_comb begin
        above_found  = 1'b0;
        above_floor  = FLOOR_NONE;
        below_found  = 1'b0;
        below_floor  = FLOOR_NONE;
        here_pending = 1'b0;
        for (int k = N_FLOORS; k >= 1; k--) begin
            if (pending_q[k] && (FLOOR_W'(k) > current_floor)) begin
                above_found = 1'b1;
                above_floor = FLOOR_W'(k);
            end
        end
        for (int k = 1; k <= N_FLOORS; k++) begin
            if (pending_q[k] && (FLOOR_W'(k) < current_floor)) begin
                below_found = 1'b1;
                below_floor = FLOOR_W'(k);
            end
            if (pending_q[k] && (FLOOR_W'(k) == current_floor)) begin
                here_pending = 1'b1;
            end
        end
    end

    // From rest, equal distances resolve towards the floor above.
    assign dist_up   = above_floor - current_floor;
    assign dist_down = current_floor - below_floor;
    assign pick_up   = above_found && (!below_found || (dist_up <= dist_down));

    // Next sweep state and target; everything holds while the car position is illegal.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        valid_d  = valid_q;
        if (floor_ok) begin
            case (state_q)
                IDLE: begin
                    if (pending_q == '0) begin
                        valid_d = 1'b0;
                    end else if (here_pending) begin
                        target_d = current_floor;
                        valid_d  = 1'b1;
                    end else if (pick_up) begin
                        state_d  = UP;
                        target_d = above_floor;
                        valid_d  = 1'b1;
                    end else begin
                        state_d  = DOWN;
                        target_d = below_floor;
                        valid_d  = 1'b1;
                    end
                end
                UP: begin
                    if (above_found) begin
                        target_d = above_floor;
                        valid_d  = 1'b1;
                    end else if (below_found) begin
                        state_d  = DOWN;
                        target_d = below_floor;
                        valid_d  = 1'b1;
                    end else if (here_pending) begin
                        target_d = current_floor;
                        valid_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end
                DOWN: begin
                    if (below_found) begin
                        target_d = below_floor;
                        valid_d  = 1'b1;
                    end else if (above_found) begin
                        state_d  = UP;
                        target_d = above_floor;
                        valid_d  = 1'b1;
                    end else if (here_pending) begin
                        target_d = current_floor;
                        valid_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
        strobe_d = valid_d && (!valid_q || (target_d != target_q));
    end

    // Scheduler FSM with registered target, strobe and direction outputs.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q    <= IDLE;
            target_q   <= FLOOR_NONE;
            valid_q    <= 1'b0;
            strobe_q   <= 1'b0;
            dir_up_q   <= 1'b0;
            dir_down_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            valid_q    <= valid_d;
            strobe_q   <= strobe_d;
            dir_up_q   <= (state_d == UP);
            dir_down_q <= (state_d == DOWN);
        end
    end

    assign target_floor  = target_q;
    assign target_valid  = valid_q;
    assign target_strobe = strobe_q;
    assign dir_up        = dir_up_q;
    assign dir_down      = dir_down_q;
    assign pending       = pending_q;

endmodule
